// File: rtl/axi4_stream_pipe.sv
// AXI4-Stream register pipeline built from cascaded full-throughput skid slices.
// Optional TUSER sideband: define AXI4_STREAM_PIPE_USER_EN.

module axis_skid_stage #(
    parameter int PW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [PW-1:0] in_dat,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [PW-1:0] out_dat
);

    typedef enum logic [1:0] {
        EMPTY,
        BUSY,
        FULL
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] m_q;
    logic [PW-1:0] s_q;
    logic          in_rdy_q;
    logic          out_vld_q;
    logic          in_xfer;
    logic          out_xfer;
    logic          ld_m_in;
    logic          ld_m_s;
    logic          ld_s;

    assign in_xfer  = in_vld & in_rdy_q;
    assign out_xfer = out_vld_q & out_rdy;
    assign in_rdy   = in_rdy_q;
    assign out_vld  = out_vld_q;
    assign out_dat  = m_q;

    // next state and register-load strobes from the two handshakes
    always_comb begin
        state_d = state_q;
        ld_m_in = 1'b0;
        ld_m_s  = 1'b0;
        ld_s    = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = BUSY;
                    ld_m_in = 1'b1;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    ld_m_in = 1'b1;
                end else if (in_xfer) begin
                    state_d = FULL;
                    ld_s    = 1'b1;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    state_d = BUSY;
                    ld_m_s  = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // state plus registered handshake flags; ready stays low through reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_rdy_q  <= (state_d != FULL);
            out_vld_q <= (state_d != EMPTY);
        end
    end

    // payload registers carry no reset; validity lives in the flags above
    always_ff @(posedge clk) begin
        if (ld_m_in) begin
            m_q <= in_dat;
        end else if (ld_m_s) begin
            m_q <= s_q;
        end
        if (ld_s) begin
            s_q <= in_dat;
        end
    end

endmodule

module axi4_stream_pipe #(
    parameter int DN     = 1,
    parameter int STAGES = 2,
    parameter int UW     = 1,
    localparam int LW    = (STAGES == 0) ? 1 : $clog2(2 * STAGES + 1)
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    input  logic          sti_TVALID,
    output logic          sti_TREADY,
    input  logic [8*DN-1:0] sti_TDATA,
    input  logic [DN-1:0] sti_TKEEP,
    input  logic          sti_TLAST,
`ifdef AXI4_STREAM_PIPE_USER_EN
    input  logic [UW-1:0] sti_TUSER,
`endif
    output logic          sto_TVALID,
    input  logic          sto_TREADY,
    output logic [8*DN-1:0] sto_TDATA,
    output logic [DN-1:0] sto_TKEEP,
    output logic          sto_TLAST,
`ifdef AXI4_STREAM_PIPE_USER_EN
    output logic [UW-1:0] sto_TUSER,
`endif
    output logic [LW-1:0] lvl
);

`ifdef AXI4_STREAM_PIPE_USER_EN
    localparam int UWI = UW;
`else
    localparam int UWI = 0;
`endif
    localparam int PW = 9 * DN + 1 + UWI;

    logic [PW-1:0] pin;
    logic [PW-1:0] pout;

`ifdef AXI4_STREAM_PIPE_USER_EN
    assign pin = {sti_TUSER, sti_TLAST, sti_TKEEP, sti_TDATA};
    assign {sto_TUSER, sto_TLAST, sto_TKEEP, sto_TDATA} = pout;
`else
    assign pin = {sti_TLAST, sti_TKEEP, sti_TDATA};
    assign {sto_TLAST, sto_TKEEP, sto_TDATA} = pout;
`endif

    generate
        if (STAGES == 0) begin : g_wire
            assign sti_TREADY = sto_TREADY;
            assign sto_TVALID = sti_TVALID;
            assign pout       = pin;
            assign lvl        = '0;
        end else begin : g_pipe
            logic [STAGES:0] vld;
            logic [STAGES:0] rdy;
            logic [PW-1:0]   dat [STAGES+1];
            logic [LW-1:0]   lvl_q;
            logic            in_x;
            logic            out_x;

            assign vld[0]      = sti_TVALID;
            assign sti_TREADY  = rdy[0];
            assign dat[0]      = pin;
            assign sto_TVALID  = vld[STAGES];
            assign rdy[STAGES] = sto_TREADY;
            assign pout        = dat[STAGES];

            for (genvar i = 0; i < STAGES; i++) begin : g_stage
                axis_skid_stage #(
                    .PW(PW)
                ) u_stage (
                    .clk    (ACLK),
                    .rst_n  (ARESETn),
                    .in_vld (vld[i]),
                    .in_rdy (rdy[i]),
                    .in_dat (dat[i]),
                    .out_vld(vld[i+1]),
                    .out_rdy(rdy[i+1]),
                    .out_dat(dat[i+1])
                );
            end

            assign in_x  = sti_TVALID & sti_TREADY;
            assign out_x = sto_TVALID & sto_TREADY;
            assign lvl   = lvl_q;

            // occupancy: up on accepted input, down on delivered output
            always_ff @(posedge ACLK or negedge ARESETn) begin
                if (!ARESETn) begin
                    lvl_q <= '0;
                end else begin
                    unique case ({in_x, out_x})
                        2'b10:   lvl_q <= lvl_q + LW'(1);
                        2'b01:   lvl_q <= lvl_q - LW'(1);
                        default: lvl_q <= lvl_q;
                    endcase
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_axi4_stream_pipe.sv
// Bench for axi4_stream_pipe: STAGES=2 scoreboard run, STAGES=3 backpressure,
// STAGES=0 passthrough; TUSER checked when AXI4_STREAM_PIPE_USER_EN is defined.

module tb_axi4_stream_pipe;

    logic clk;
    logic rst_n;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic [2:0]  u;
    } beat_t;

    // DUT A: STAGES=2
    logic        vld_a, rdy_a, last_a, ovld_a, ordy_a, olast_a;
    logic [31:0] dat_a, odat_a;
    logic [3:0]  keep_a, okeep_a;
    logic [2:0]  user_a, ouser_a;
    logic [2:0]  lvl_a;

    // DUT B: STAGES=3
    logic        vld_b, rdy_b, last_b, ovld_b, ordy_b, olast_b;
    logic [31:0] dat_b, odat_b;
    logic [3:0]  keep_b, okeep_b;
    logic [2:0]  user_b, ouser_b;
    logic [2:0]  lvl_b;

    // DUT Z: STAGES=0
    logic        vld_z, rdy_z, last_z, ovld_z, ordy_z, olast_z;
    logic [31:0] dat_z, odat_z;
    logic [3:0]  keep_z, okeep_z;
    logic [2:0]  user_z, ouser_z;
    logic [0:0]  lvl_z;

    int total = 0;
    int bad   = 0;

    beat_t q[$];
    int    n_in  = 0;
    int    n_out = 0;

    axi4_stream_pipe #(.DN(4), .STAGES(2), .UW(3)) dut_a (
        .ACLK(clk), .ARESETn(rst_n),
        .sti_TVALID(vld_a), .sti_TREADY(rdy_a), .sti_TDATA(dat_a),
        .sti_TKEEP(keep_a), .sti_TLAST(last_a),
`ifdef AXI4_STREAM_PIPE_USER_EN
        .sti_TUSER(user_a), .sto_TUSER(ouser_a),
`endif
        .sto_TVALID(ovld_a), .sto_TREADY(ordy_a), .sto_TDATA(odat_a),
        .sto_TKEEP(okeep_a), .sto_TLAST(olast_a), .lvl(lvl_a)
    );

    axi4_stream_pipe #(.DN(4), .STAGES(3), .UW(3)) dut_b (
        .ACLK(clk), .ARESETn(rst_n),
        .sti_TVALID(vld_b), .sti_TREADY(rdy_b), .sti_TDATA(dat_b),
        .sti_TKEEP(keep_b), .sti_TLAST(last_b),
`ifdef AXI4_STREAM_PIPE_USER_EN
        .sti_TUSER(user_b), .sto_TUSER(ouser_b),
`endif
        .sto_TVALID(ovld_b), .sto_TREADY(ordy_b), .sto_TDATA(odat_b),
        .sto_TKEEP(okeep_b), .sto_TLAST(olast_b), .lvl(lvl_b)
    );

    axi4_stream_pipe #(.DN(4), .STAGES(0), .UW(3)) dut_z (
        .ACLK(clk), .ARESETn(rst_n),
        .sti_TVALID(vld_z), .sti_TREADY(rdy_z), .sti_TDATA(dat_z),
        .sti_TKEEP(keep_z), .sti_TLAST(last_z),
`ifdef AXI4_STREAM_PIPE_USER_EN
        .sti_TUSER(user_z), .sto_TUSER(ouser_z),
`endif
        .sto_TVALID(ovld_z), .sto_TREADY(ordy_z), .sto_TDATA(odat_z),
        .sto_TKEEP(okeep_z), .sto_TLAST(olast_z), .lvl(lvl_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for DUT A: FIFO model of accepted beats, checked each cycle
    always @(negedge clk) begin
        beat_t b;
        if (!rst_n) begin
            q.delete();
            n_in  = 0;
            n_out = 0;
            chk("a_rst_vld", ovld_a, 0);
            chk("a_rst_rdy", rdy_a, 0);
            chk("a_rst_lvl", lvl_a, 0);
        end else begin
            chk("a_lvl", lvl_a, n_in - n_out);
            chk("a_cap", q.size() <= 4, 1);
            if (ovld_a) begin
                chk("a_have_beat", q.size() > 0, 1);
                if (q.size() > 0) begin
                    chk("a_data", odat_a, q[0].d);
                    chk("a_keep", okeep_a, q[0].k);
                    chk("a_last", olast_a, q[0].l);
`ifdef AXI4_STREAM_PIPE_USER_EN
                    chk("a_user", ouser_a, q[0].u);
`endif
                    if (ordy_a) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end
            if (vld_a && rdy_a) begin
                b.d = dat_a;
                b.k = keep_a;
                b.l = last_a;
                b.u = user_a;
                q.push_back(b);
                n_in++;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    ein;
        int    eo;
        int    acc;
        int    steps;
        int    k;
        int    n;
        bit    rdy_seen;
        bit    r;

        rst_n  = 1'b0;
        vld_a  = 0; dat_a = 0; keep_a = 0; last_a = 0; user_a = 0;
        ordy_a = 0;
        vld_b  = 0; dat_b = 0; keep_b = 0; last_b = 0; user_b = 0;
        ordy_b = 0;
        vld_z  = 0; dat_z = 0; keep_z = 0; last_z = 0; user_z = 0;
        ordy_z = 1;

        // reset state; passthrough ignores reset
        #1;
        chk("rst_a_vld", ovld_a, 0);
        chk("rst_a_rdy", rdy_a, 0);
        chk("rst_a_lvl", lvl_a, 0);
        chk("rst_b_rdy", rdy_b, 0);
        chk("rst_z_rdy", rdy_z, 1);
        step();
        step();
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rel_a_rdy_before", rdy_a, 0);
        step();
        chk("rel_a_rdy_after", rdy_a, 1);
        chk("rel_b_rdy_after", rdy_b, 1);

        // 16-beat stream at full rate through STAGES=2
        ordy_a = 1;
        for (int c = 0; c < 20; c++) begin
            if (c < 16) begin
                vld_a  = 1;
                dat_a  = c;
                keep_a = 4'hF;
                last_a = (c == 15);
                user_a = 3'(c % 8);
                chk("s_rdy", rdy_a, 1);
            end else begin
                vld_a = 0;
            end
            ein = (c < 16) ? c : 16;
            eo  = (c < 2) ? 0 : ((c - 2 > 16) ? 16 : c - 2);
            chk("s_vld", ovld_a, (c >= 2 && c <= 17));
            if (c >= 2 && c <= 17) chk("s_dat", odat_a, c - 2);
            chk("s_lvl", lvl_a, ein - eo);
            step();
        end

        // fill 3 beats, then reset mid-packet
        ordy_a = 0;
        for (int i = 0; i < 3; i++) begin
            vld_a  = 1;
            dat_a  = 32'h100 + i;
            keep_a = 4'(i + 1);
            last_a = 0;
            user_a = 3'(i);
            chk("f_rdy", rdy_a, 1);
            step();
        end
        vld_a = 0;
        chk("f_lvl", lvl_a, 3);
        chk("f_vld", ovld_a, 1);
        chk("f_dat", odat_a, 32'h100);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_vld", ovld_a, 0);
        chk("mr_lvl", lvl_a, 0);
        chk("mr_rdy", rdy_a, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("mr_rdy_before", rdy_a, 0);
        step();
        chk("mr_rdy_after", rdy_a, 1);
        chk("mr_lvl_after", lvl_a, 0);
        chk("mr_vld_after", ovld_a, 0);

        // random valid/ready traffic, 10000 beats
        acc      = 0;
        steps    = 0;
        rdy_seen = 0;
        vld_a    = 0;
        forever begin
            if (vld_a && rdy_seen) acc++;
            if (acc >= 10000 || steps >= 60000) break;
            if (!vld_a || rdy_seen) begin
                vld_a  = 1'($urandom_range(0, 1));
                dat_a  = $urandom;
                keep_a = 4'($urandom);
                last_a = 1'($urandom);
                user_a = 3'(acc % 8);
            end
            ordy_a   = 1'($urandom_range(0, 1));
            rdy_seen = rdy_a;
            step();
            steps++;
        end
        vld_a = 0;
        chk("r_accepted", acc, 10000);
        ordy_a = 1;
        for (int i = 0; i < 30; i++) begin
            if (q.size() == 0 && !ovld_a) break;
            step();
        end
        step();
        chk("r_drain_q", q.size(), 0);
        chk("r_drain_lvl", lvl_a, 0);
        chk("r_drain_vld", ovld_a, 0);
        chk("r_nin", n_in, 10000);
        chk("r_nout", n_out, 10000);

        // backpressure on STAGES=3: exactly 6 beats absorbed
        ordy_b = 0;
        k = 0;
        for (int s = 0; s < 10; s++) begin
            vld_b  = 1;
            dat_b  = k;
            keep_b = 4'hF;
            last_b = (k == 5);
            user_b = 3'(k % 8);
            r = rdy_b;
            step();
            if (r) k++;
        end
        vld_b = 0;
        chk("bp_acc", k, 6);
        chk("bp_rdy", rdy_b, 0);
        chk("bp_lvl", lvl_b, 6);
        chk("bp_vld", ovld_b, 1);
        ordy_b = 1;
        n = 0;
        for (int s = 0; s < 12; s++) begin
            if (ovld_b) begin
                chk("bp_order", odat_b, n);
                chk("bp_last", olast_b, (n == 5));
                n++;
            end
            step();
        end
        chk("bp_nout", n, 6);
        chk("bp_lvl_end", lvl_b, 0);

        // STAGES=0 passthrough
        for (int i = 0; i < 8; i++) begin
            ordy_z = 1'(i % 2);
            vld_z  = 1'($urandom);
            dat_z  = $urandom;
            keep_z = 4'($urandom);
            last_z = 1'($urandom);
            user_z = 3'($urandom);
            #1;
            chk("z_rdy", rdy_z, ordy_z);
            chk("z_vld", ovld_z, vld_z);
            chk("z_dat", odat_z, dat_z);
            chk("z_keep", okeep_z, keep_z);
            chk("z_last", olast_z, last_z);
`ifdef AXI4_STREAM_PIPE_USER_EN
            chk("z_user", ouser_z, user_z);
`endif
            chk("z_lvl", lvl_z, 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
